// File: rtl/yin_pkg.sv
// Shared YIN pitch-path definitions: scheduler states and frame length helper.
// Used by yin_frame_scheduler and the min_tau top-level wrapper.
package yin_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Samples the core needs: analysis window plus the full lag range.
    function automatic int frame_len(input int window_size_bits, input int max_tau);
        return (1 << window_size_bits) + max_tau;
    endfunction

endpackage

// File: rtl/yin_frame_scheduler_if.sv
// Stream-side handshakes of the frame scheduler: sample input and tau result.
// master = sample source / result sink, slave = scheduler.
interface yin_frame_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] sample_in;
    logic                  sample_valid;
    logic                  sample_ready;
    logic [7:0]            tau_out;
    logic                  tau_valid;
    logic                  tau_ack;

    modport master (
        output sample_in, sample_valid, tau_ack,
        input  sample_ready, tau_out, tau_valid
    );

    modport slave (
        input  sample_in, sample_valid, tau_ack,
        output sample_ready, tau_out, tau_valid
    );
endinterface

// File: rtl/frame_shift_buffer.sv
// Frame shift register: clk, reset (sync, active-low), shift_en, din in;
// dout out, flat frame with the oldest sample in the LSBs.
module frame_shift_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 296
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            shift_en,
    input  logic [DATA_WIDTH-1:0]           din,
    output logic [FRAME_LEN*DATA_WIDTH-1:0] dout
);
    localparam int W = FRAME_LEN * DATA_WIDTH;

    // New sample enters at the top; the oldest falls off the bottom.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout <= '0;
        end else if (shift_en) begin
            dout <= {din, dout[W-1:DATA_WIDTH]};
        end
    end
endmodule

// File: rtl/yin_frame_scheduler.sv
// Frame sequencer for min_tau_module: fills overlapping frames, runs the core with a watchdog.
// Ports: clk, reset (sync, active-low), bus (samples/tau), core_data/core_reset/core_ready/core_min_tau, timeout_err, frame_count.
module yin_frame_scheduler
    import yin_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int WINDOW_SIZE_BITS = 8,
    parameter int MAX_TAU          = 40,
    parameter int HOP              = 64,
    parameter int TIMEOUT_CYCLES   = 65535,
    localparam int FRAME_LEN       = frame_len(WINDOW_SIZE_BITS, MAX_TAU)
) (
    input  logic                            clk,
    input  logic                            reset,
    yin_frame_scheduler_if.slave            bus,
    output logic [FRAME_LEN*DATA_WIDTH-1:0] core_data,
    output logic                            core_reset,
    input  logic                            core_ready,
    input  logic [7:0]                      core_min_tau,
    output logic                            timeout_err,
    output logic [15:0]                     frame_count
);
    localparam int FILL_W = $clog2(FRAME_LEN + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FILL_W-1:0] FILL_LAST   = FILL_W'(FRAME_LEN - 1);
    localparam logic [FILL_W-1:0] FILL_REFILL = FILL_W'(FRAME_LEN - HOP);
    localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              launch_q, launch_d;
    logic [7:0]        tau_q, tau_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              ready_q;
    logic              core_rst_q;
    logic              accept;

    assign accept = bus.sample_valid & ready_q;

    frame_shift_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAME_LEN  (FRAME_LEN)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .shift_en (accept),
        .din      (bus.sample_in),
        .dout     (core_data)
    );

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        wd_d     = wd_q;
        launch_d = launch_q;
        tau_d    = tau_q;
        valid_d  = valid_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == FILL_LAST) begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                // Two cycles of core reset; launch_q marks the second one.
                launch_d = ~launch_q;
                if (launch_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wd_d = wd_q + 1'b1;
                // A result arriving on the last watchdog cycle still counts.
                if (core_ready) begin
                    tau_d   = core_min_tau;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = HOLD;
                end else if (wd_q == WD_LAST) begin
                    tau_d   = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.tau_ack && valid_q) begin
                    valid_d = 1'b0;
                    fill_d  = FILL_REFILL;
                    wd_d    = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // ready and core reset are registered decodes of the next state so
    // both read as their reset values in the cycle after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= FILL;
            fill_q     <= '0;
            wd_q       <= '0;
            launch_q   <= 1'b0;
            tau_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            wd_q       <= wd_d;
            launch_q   <= launch_d;
            tau_q      <= tau_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            ready_q    <= (state_d == FILL);
            core_rst_q <= (state_d != RUN);
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.tau_out      = tau_q;
    assign bus.tau_valid    = valid_q;
    assign core_reset       = core_rst_q;
    assign timeout_err      = err_q;
    assign frame_count      = cnt_q;
endmodule

// File: tb/tb_yin_frame_scheduler.sv
// Directed bench for yin_frame_scheduler with a cycle-counting core model.
// Frame table plus hand sequences for latency, timeout and mid-frame reset.
module tb_yin_frame_scheduler;
    localparam int DW  = 8;
    localparam int WSB = 3;
    localparam int MT  = 4;
    localparam int HOP = 4;
    localparam int TO  = 20;
    localparam int FL  = 12;
    localparam int W   = FL * DW;

    typedef struct {
        int         ready_at;
        logic [7:0] tau;
        int         hold;
        bit         keep;
        int         e_lat;
        logic [7:0] e_tau;
        bit         e_err;
        int         e_cnt;
        int         e_lsb;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] core_data;
    logic         core_reset;
    logic         core_ready;
    logic [7:0]   core_min_tau;
    logic         timeout_err;
    logic [15:0]  frame_count;

    int         ready_at = -1;
    logic [7:0] tau_val = 8'd0;
    int         run_cnt = 0;
    int         next_val = 1;
    int         n_pass = 0;
    int         n_total = 0;
    vec_t       vecs[4];

    yin_frame_scheduler_if #(.DATA_WIDTH(DW)) bus ();

    yin_frame_scheduler #(
        .DATA_WIDTH       (DW),
        .WINDOW_SIZE_BITS (WSB),
        .MAX_TAU          (MT),
        .HOP              (HOP),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .core_data    (core_data),
        .core_reset   (core_reset),
        .core_ready   (core_ready),
        .core_min_tau (core_min_tau),
        .timeout_err  (timeout_err),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    // Core model: counts cycles out of reset, raises ready at ready_at.
    always @(posedge clk) run_cnt <= core_reset ? 0 : run_cnt + 1;
    assign core_ready   = (ready_at >= 0) && !core_reset && (run_cnt == ready_at);
    assign core_min_tau = tau_val;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    function automatic logic [W-1:0] exp_frame(input int lsb);
        logic [W-1:0] f;
        f = '0;
        for (int i = 0; i < FL; i++) f[i*DW +: DW] = 8'(lsb + i);
        return f;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, W'(bus.sample_ready), 0);
        chk({tag, "_core_reset"}, W'(core_reset), 1);
        chk({tag, "_tau_valid"}, W'(bus.tau_valid), 0);
        chk({tag, "_tau_out"}, W'(bus.tau_out), 0);
        chk({tag, "_err"}, W'(timeout_err), 0);
        chk({tag, "_count"}, W'(frame_count), 0);
        chk({tag, "_data"}, core_data, 0);
    endtask

    // Offer n stream values; leaves the bench just after the last accept edge.
    task automatic feed(input int n, input bit keep);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 200) begin
            @(negedge clk);
            bus.sample_in    = 8'(next_val);
            bus.sample_valid = 1'b1;
            if (bus.sample_ready) begin
                got++;
                next_val++;
            end
            guard++;
        end
        if (got < n) chk("feed_guard", W'(got), W'(n));
        @(posedge clk);
        #1;
        if (keep) bus.sample_in = 8'(next_val);
        else bus.sample_valid = 1'b0;
    endtask

    task automatic watch(output int lat, output logic [W-1:0] d1,
                         output bit cr_ok, output bit idle_ok);
        lat = 0;
        d1 = '0;
        cr_ok = 1'b1;
        idle_ok = 1'b1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (lat == 1) d1 = core_data;
            if (bus.sample_ready || core_data !== d1) idle_ok = 1'b0;
            if (bus.tau_valid) break;
            if (lat <= 2 && !core_reset) cr_ok = 1'b0;
            if (lat >= 3 && core_reset) cr_ok = 1'b0;
        end
    endtask

    task automatic ack(input string tag, input int hold, input logic [7:0] e_tau);
        bit st = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!bus.tau_valid || bus.tau_out !== e_tau || !core_reset) st = 1'b0;
        end
        @(negedge clk);
        bus.tau_ack      = 1'b1;
        bus.sample_valid = 1'b0;
        @(posedge clk);
        #1 bus.tau_ack = 1'b0;
        @(negedge clk);
        chk({tag, "_held"}, W'(st), 1);
        chk({tag, "_acked"}, W'(bus.tau_valid), 0);
        chk({tag, "_refill"}, W'(bus.sample_ready), 1);
    endtask

    task automatic run_frame(input string tag, input int n_new, input int r,
                             input logic [7:0] tv, input int hold, input bit keep,
                             input int e_lat, input logic [7:0] e_tau, input bit e_err,
                             input int e_cnt, input int e_lsb);
        int           lat;
        logic [W-1:0] d1;
        bit           cr_ok;
        bit           idle_ok;
        ready_at = r;
        tau_val  = tv;
        feed(n_new, keep);
        watch(lat, d1, cr_ok, idle_ok);
        chk({tag, "_latency"}, W'(lat), W'(e_lat));
        chk({tag, "_frame"}, d1, exp_frame(e_lsb));
        chk({tag, "_core_reset"}, W'(cr_ok), 1);
        chk({tag, "_idle"}, W'(idle_ok), 1);
        chk({tag, "_tau_out"}, W'(bus.tau_out), W'(e_tau));
        chk({tag, "_tau_valid"}, W'(bus.tau_valid), 1);
        chk({tag, "_err"}, W'(timeout_err), W'(e_err));
        chk({tag, "_count"}, W'(frame_count), W'(e_cnt));
        ack(tag, hold, e_tau);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] d1;
        bit           cr_ok;
        bit           idle_ok;

        vecs[0] = '{ready_at: 3,  tau: 8'd0,   hold: 2, keep: 1'b0,
                    e_lat: 7,  e_tau: 8'd0,   e_err: 1'b0, e_cnt: 2, e_lsb: 5};
        vecs[1] = '{ready_at: 19, tau: 8'd99,  hold: 0, keep: 1'b0,
                    e_lat: 23, e_tau: 8'd99,  e_err: 1'b0, e_cnt: 3, e_lsb: 9};
        vecs[2] = '{ready_at: -1, tau: 8'd77,  hold: 1, keep: 1'b1,
                    e_lat: 23, e_tau: 8'd0,   e_err: 1'b1, e_cnt: 4, e_lsb: 13};
        vecs[3] = '{ready_at: 5,  tau: 8'd200, hold: 3, keep: 1'b0,
                    e_lat: 9,  e_tau: 8'd200, e_err: 1'b1, e_cnt: 5, e_lsb: 17};

        bus.sample_in    = '0;
        bus.sample_valid = 1'b0;
        bus.tau_ack      = 1'b0;
        reset            = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        reset = 1'b1;

        run_frame("first", FL, 10, 8'd7, 5, 1'b0, 14, 8'd7, 1'b0, 1, 1);

        foreach (vecs[i]) begin
            run_frame($sformatf("vec%0d", i), HOP, vecs[i].ready_at, vecs[i].tau,
                      vecs[i].hold, vecs[i].keep, vecs[i].e_lat, vecs[i].e_tau,
                      vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_lsb);
        end

        ready_at = -1;
        feed(HOP, 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("rst_run");
        reset = 1'b1;

        feed(FL - 1, 1'b0);
        @(negedge clk);
        chk("partial_ready", W'(bus.sample_ready), 1);
        run_frame("after_run", 1, 2, 8'd5, 1, 1'b0, 6, 8'd5, 1'b0, 1, 33);

        @(negedge clk);
        bus.tau_ack = 1'b1;
        @(negedge clk);
        bus.tau_ack = 1'b0;
        chk("stray_ack_valid", W'(bus.tau_valid), 0);
        chk("stray_ack_count", W'(frame_count), 1);
        chk("stray_ack_ready", W'(bus.sample_ready), 1);

        ready_at = 1;
        tau_val  = 8'd9;
        feed(HOP, 1'b0);
        watch(lat, d1, cr_ok, idle_ok);
        chk("pre_hold_latency", W'(lat), 5);
        chk("pre_hold_frame", d1, exp_frame(37));
        chk("pre_hold_tau", W'(bus.tau_out), 9);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_reset("rst_hold");
        reset = 1'b1;

        run_frame("after_hold", FL, 0, 8'h3c, 0, 1'b0, 4, 8'h3c, 1'b0, 1, 49);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
